uart_rx_axis: RTL

//  UART receiver (8N1, LSB first) for the serial<->AXIS bridge. Samples the asynchronous
//  rx line using the 16x-oversample tick from the NCO baud rate generator.

---
 rtl/uart_rx_axis.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver sampled on a 16x oversample tick, delivering bytes on an
// AXI4-Stream master port with one-cycle framing-error and overrun pulses.
module uart_rx_axis #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       baud_x16_i,
    input  logic       rx_i,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HI
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             deliver_q, deliver_d;
    logic             frame_err_d;

    // Synchronizer presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments only; the
    // combinational block below computes every *_d from the *_q values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
            frame_err_o <= frame_err_d;
        end
    end

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        deliver_d   = 1'b0;
        frame_err_d = 1'b0;

        if (baud_x16_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end
                end

                ST_START: begin
                    if (cnt_q == CNT_MID) begin
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = ST_STOP;
                            bit_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        bit_d = '0;
                        if (rx_s) begin
                            state_d   = ST_IDLE;
                            deliver_d = 1'b1;
                        end else begin
                            state_d     = ST_WAIT_HI;
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_WAIT_HI: begin
                    // A held break must return high before another start is accepted.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    // Output holding register: a new byte replaces the held one only when the
    // held one is being accepted in the same cycle; otherwise it is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (deliver_q) begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    m_axis_tdata  <= shift_q;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
